// File: rtl/gt_qpll_seq_pkg.sv
// gt_qpll_seq_pkg: shared state type and counter sizing for the QPLL reset sequencer
package gt_qpll_seq_pkg;
  typedef enum logic [2:0] {IDLE, RESET, WAIT_LOCK, LOCKED, FAILED} qpll_state_e;
  localparam int RETRY_W = 4;
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/gt_qpll_chan_fsm.sv
// gt_qpll_chan_fsm: one quad's lock synchroniser, counters and reset FSM (lock-loss counter when GT_QPLL_LOSS_CNT_EN is defined)
module gt_qpll_chan_fsm
  import gt_qpll_seq_pkg::*;
#(
  parameter int RESET_CYCLES = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 32,
  parameter int MAX_RETRIES  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               lock_raw,
  output logic               qpll_reset,
  output logic               locked,
  output logic               failed,
  output logic [RETRY_W-1:0] retry
`ifdef GT_QPLL_LOSS_CNT_EN
  ,
  output logic [7:0]         loss_cnt
`endif
);
  localparam int RC_W = cnt_w(RESET_CYCLES);
  localparam int TO_W = cnt_w(LOCK_TIMEOUT);
  localparam int ST_W = cnt_w(LOCK_STABLE);
  qpll_state_e     state;
  logic [RC_W-1:0] rst_cnt;
  logic [TO_W-1:0] tmo_cnt;
  logic [ST_W-1:0] stb_cnt;
  logic [1:0]      sync;
  logic            lock_s;
  logic            lost;
  assign lock_s = sync[1];
  assign lost   = state == LOCKED && !lock_s && !start;
  // two-flop lock synchroniser, held clear while the PLL is in reset so stale lock never counts
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= qpll_reset ? 2'b00 : {sync[0], lock_raw};
  // reset/lock sequencing; start overrides every other transition
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      rst_cnt    <= '0;
      tmo_cnt    <= '0;
      stb_cnt    <= '0;
      retry      <= '0;
      locked     <= 1'b0;
      failed     <= 1'b0;
      qpll_reset <= 1'b1;
    end else if (start) begin
      state      <= RESET;
      rst_cnt    <= '0;
      retry      <= '0;
      locked     <= 1'b0;
      failed     <= 1'b0;
      qpll_reset <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state   <= RESET;
          rst_cnt <= '0;
        end
        RESET:
          if (rst_cnt == RC_W'(RESET_CYCLES - 1)) begin
            state      <= WAIT_LOCK;
            qpll_reset <= 1'b0;
            tmo_cnt    <= '0;
            stb_cnt    <= '0;
          end else rst_cnt <= rst_cnt + 1'b1;
        WAIT_LOCK: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          stb_cnt <= lock_s ? stb_cnt + 1'b1 : '0;
          if (lock_s && stb_cnt == ST_W'(LOCK_STABLE - 1)) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end else if (tmo_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
            qpll_reset <= 1'b1;
            rst_cnt    <= '0;
            if (retry < RETRY_W'(MAX_RETRIES)) begin
              retry <= retry + 1'b1;
              state <= RESET;
            end else begin
              state  <= FAILED;
              failed <= 1'b1;
            end
          end
        end
        LOCKED:
          if (lost) begin
            state      <= RESET;
            locked     <= 1'b0;
            qpll_reset <= 1'b1;
            rst_cnt    <= '0;
            retry      <= retry == '1 ? retry : retry + 1'b1;
          end
        FAILED: ;
        default: state <= IDLE;
      endcase
    end
`ifdef GT_QPLL_LOSS_CNT_EN
  // lock-loss history survives start; only power-on reset clears it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) loss_cnt <= '0;
    else if (lost && loss_cnt != 8'hff) loss_cnt <= loss_cnt + 1'b1;
`endif
endmodule

// File: rtl/gt_qpll_reset_sequencer.sv
// gt_qpll_reset_sequencer: per-quad QPLL reset/lock sequencing with aggregate readiness (GT_QPLL_LOSS_CNT_EN adds lock_loss_cnt)
module gt_qpll_reset_sequencer
  import gt_qpll_seq_pkg::*;
#(
  parameter int N_COMMON     = 2,
  parameter int RESET_CYCLES = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 32,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [N_COMMON-1:0]           qpll0lock,
  output logic [N_COMMON-1:0]           qpll0reset,
  output logic [N_COMMON-1:0]           quad_locked,
  output logic [N_COMMON-1:0]           quad_fail,
  output logic                          all_locked,
  output logic [RETRY_W*N_COMMON-1:0]   retry_cnt
`ifdef GT_QPLL_LOSS_CNT_EN
  ,
  output logic [8*N_COMMON-1:0]         lock_loss_cnt
`endif
);
  for (genvar i = 0; i < N_COMMON; i++) begin : g_quad
    gt_qpll_chan_fsm #(
      .RESET_CYCLES(RESET_CYCLES),
      .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .LOCK_STABLE (LOCK_STABLE),
      .MAX_RETRIES (MAX_RETRIES)
    ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .lock_raw  (qpll0lock[i]),
      .qpll_reset(qpll0reset[i]),
      .locked    (quad_locked[i]),
      .failed    (quad_fail[i]),
      .retry     (retry_cnt[RETRY_W*i +: RETRY_W])
`ifdef GT_QPLL_LOSS_CNT_EN
      ,
      .loss_cnt  (lock_loss_cnt[8*i +: 8])
`endif
    );
  end
  // aggregate readiness, registered one cycle behind the per-quad flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) all_locked <= 1'b0;
    else all_locked <= &quad_locked;
endmodule

// File: tb/tb_gt_qpll_reset_sequencer.sv
// tb_gt_qpll_reset_sequencer: scenario tasks plus randomized lock traffic against a timestamp-based reference model
module tb_gt_qpll_reset_sequencer;
  localparam int N = 2, RC = 16, TO = 256, ST = 8, MR = 2;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] qpll0lock = 2'b00;
  logic [1:0] qpll0reset, quad_locked, quad_fail;
  logic       all_locked;
  logic [7:0] retry_cnt;
`ifdef GT_QPLL_LOSS_CNT_EN
  logic [15:0] lock_loss_cnt;
`endif
  int checks = 0, passed = 0, cyc = 0;
  int ph[2], rel_at[2], run[2], m_retry[2], m_loss[2];
  bit m_rst[2], m_lk[2], m_fl[2], p0[2], p1[2];
  bit m_all;

  always #5 clk = ~clk;

  gt_qpll_reset_sequencer #(
    .N_COMMON(N), .RESET_CYCLES(RC), .LOCK_TIMEOUT(TO), .LOCK_STABLE(ST), .MAX_RETRIES(MR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .qpll0lock  (qpll0lock),
    .qpll0reset (qpll0reset),
    .quad_locked(quad_locked),
    .quad_fail  (quad_fail),
    .all_locked (all_locked),
    .retry_cnt  (retry_cnt)
`ifdef GT_QPLL_LOSS_CNT_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  task automatic restart(input int q);
    m_rst[q] = 1'b1; m_lk[q] = 1'b0; rel_at[q] = cyc + RC; ph[q] = 1;
  endtask

  // model phases: 0 power-up, 1 reset held until rel_at, 2 waiting for lock, 3 locked, 4 failed
  task automatic step();
    bit nxt_all, ls;
    cyc++;
    if (!rst_n) begin
      for (int q = 0; q < N; q++) begin
        ph[q] = 0; m_rst[q] = 1'b1; m_lk[q] = 1'b0; m_fl[q] = 1'b0;
        m_retry[q] = 0; m_loss[q] = 0; p0[q] = 1'b0; p1[q] = 1'b0;
      end
      m_all = 1'b0;
      return;
    end
    nxt_all = m_lk[0] && m_lk[1];
    for (int q = 0; q < N; q++) begin
      ls = p1[q];
      p1[q] = m_rst[q] ? 1'b0 : p0[q];
      p0[q] = m_rst[q] ? 1'b0 : qpll0lock[q];
      if (start) begin
        m_retry[q] = 0; m_fl[q] = 1'b0; restart(q);
      end else if (ph[q] == 0) restart(q);
      else if (ph[q] == 1) begin
        if (cyc == rel_at[q]) begin m_rst[q] = 1'b0; run[q] = 0; ph[q] = 2; end
      end else if (ph[q] == 2) begin
        run[q] = ls ? run[q] + 1 : 0;
        if (run[q] == ST) begin m_lk[q] = 1'b1; ph[q] = 3; end
        else if (cyc - rel_at[q] == TO) begin
          if (m_retry[q] < MR) begin m_retry[q]++; restart(q); end
          else begin m_fl[q] = 1'b1; m_rst[q] = 1'b1; ph[q] = 4; end
        end
      end else if (ph[q] == 3 && !ls) begin
        m_retry[q] = m_retry[q] < 15 ? m_retry[q] + 1 : 15;
        m_loss[q] = m_loss[q] < 255 ? m_loss[q] + 1 : 255;
        restart(q);
      end
    end
    m_all = nxt_all;
  endtask

  task automatic tick();
    @(posedge clk);
    step();
    @(negedge clk);
  endtask

  function automatic logic [16:0] exp_vec();
    return {m_rst[1], m_rst[0], m_lk[1], m_lk[0], m_fl[1], m_fl[0], m_all, 4'(m_retry[1]), 4'(m_retry[0])};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {qpll0reset, quad_locked, quad_fail, all_locked, retry_cnt};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; qpll0lock = 2'b00;
    repeat (3) tick();
    checks++; if (qpll0reset !== 2'b11) $display("FAIL reset_qpll0reset got %b want 11", qpll0reset); else passed++;
    checks++; if ({quad_locked, quad_fail, all_locked} !== 5'b0) $display("FAIL reset_status got %b want 00000", {quad_locked, quad_fail, all_locked}); else passed++;
    checks++; if (retry_cnt !== 8'h00) $display("FAIL reset_retry got %h want 00", retry_cnt); else passed++;
    checks++; if (obs_vec() !== exp_vec()) $display("FAIL reset_model got %h want %h", obs_vec(), exp_vec()); else passed++;
  endtask

  task automatic test_power_up();
    int fall = 0, lk = 0, al = 0;
    qpll0lock = 2'b11; rst_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++; if (obs_vec() !== exp_vec()) $display("FAIL pwr_cycle%0d got %h want %h", i, obs_vec(), exp_vec()); else passed++;
      if (fall == 0 && qpll0reset == 2'b00) fall = i;
      if (lk == 0 && quad_locked == 2'b11) lk = i;
      if (al == 0 && all_locked) al = i;
    end
    checks++; if (fall != 1 + RC) $display("FAIL pwr_reset_release got edge %0d want %0d", fall, 1 + RC); else passed++;
    checks++; if (lk - fall != 2 + ST) $display("FAIL pwr_lock_delay got %0d want %0d", lk - fall, 2 + ST); else passed++;
    checks++; if (al - lk != 1) $display("FAIL pwr_all_locked_lag got %0d want 1", al - lk); else passed++;
  endtask

  task automatic test_quad1_fail();
    int falls = 0, f = -1, seq = 0;
    int lows[$], steps[$];
    logic prev;
    logic [3:0] last_r;
    qpll0lock = 2'b01; start = 1'b1; tick(); start = 1'b0;
    prev = qpll0reset[1]; last_r = retry_cnt[7:4];
    for (int i = 1; i <= 830; i++) begin
      tick();
      checks++; if (obs_vec() !== exp_vec()) $display("FAIL q1fail_cycle%0d got %h want %h", i, obs_vec(), exp_vec()); else passed++;
      if (prev && !qpll0reset[1]) begin falls++; f = i; end
      if (!prev && qpll0reset[1] && f >= 0) lows.push_back(i - f);
      if (retry_cnt[7:4] != last_r) begin steps.push_back(int'(retry_cnt[7:4])); last_r = retry_cnt[7:4]; end
      prev = qpll0reset[1];
    end
    foreach (steps[k]) seq = seq * 16 + steps[k];
    checks++; if (falls != 3) $display("FAIL q1_reset_pulses got %0d want 3", falls); else passed++;
    checks++; if (lows.size() != 3) $display("FAIL q1_low_periods got %0d want 3", lows.size()); else passed++;
    foreach (lows[k]) begin
      checks++; if (lows[k] != TO) $display("FAIL q1_low_len%0d got %0d want %0d", k, lows[k], TO); else passed++;
    end
    checks++; if (seq != 'h12) $display("FAIL q1_retry_steps got %h want 12", seq); else passed++;
    checks++; if (quad_fail !== 2'b10) $display("FAIL q1_quad_fail got %b want 10", quad_fail); else passed++;
    checks++; if (qpll0reset[1] !== 1'b1) $display("FAIL q1_held_reset got %b want 1", qpll0reset[1]); else passed++;
    checks++; if ({quad_locked[0], retry_cnt[3:0]} !== 5'b10000) $display("FAIL q0_unaffected got %b want 10000", {quad_locked[0], retry_cnt[3:0]}); else passed++;
  endtask

  task automatic test_glitch();
    int lj = 0;
    qpll0lock = 2'b10; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 40 && qpll0reset[0]; i++) tick();
    checks++; if (qpll0reset[0] !== 1'b0) $display("FAIL glitch_release got %b want 0", qpll0reset[0]); else passed++;
    for (int j = 1; j <= 30; j++) begin
      qpll0lock[0] = (j != 8);
      tick();
      checks++; if (obs_vec() !== exp_vec()) $display("FAIL glitch_cycle%0d got %h want %h", j, obs_vec(), exp_vec()); else passed++;
      if (lj == 0 && quad_locked[0]) lj = j;
    end
    checks++; if (lj != 10 + ST) $display("FAIL glitch_lock_edge got %0d want %0d", lj, 10 + ST); else passed++;
  endtask

  task automatic test_lock_loss();
    int lf = 0, rr = 0, rf = 0, rl = 0;
    for (int i = 0; i < 60 && !all_locked; i++) tick();
    checks++; if (all_locked !== 1'b1) $display("FAIL loss_pre_all_locked got %b want 1", all_locked); else passed++;
    for (int j = 1; j <= 40; j++) begin
      qpll0lock[0] = (j != 1);
      tick();
      checks++; if (obs_vec() !== exp_vec()) $display("FAIL loss_cycle%0d got %h want %h", j, obs_vec(), exp_vec()); else passed++;
      if (lf == 0 && !quad_locked[0]) lf = j;
      if (rr == 0 && qpll0reset[0]) rr = j;
      if (rr != 0 && rf == 0 && !qpll0reset[0]) rf = j;
      if (lf != 0 && rl == 0 && quad_locked[0]) rl = j;
    end
    checks++; if (lf != 3) $display("FAIL loss_unlock_edge got %0d want 3", lf); else passed++;
    checks++; if (rr != 3) $display("FAIL loss_reset_edge got %0d want 3", rr); else passed++;
    checks++; if (rf - rr != RC) $display("FAIL loss_reset_len got %0d want %0d", rf - rr, RC); else passed++;
    checks++; if (rl != 3 + RC + 2 + ST) $display("FAIL loss_relock_edge got %0d want %0d", rl, 3 + RC + 2 + ST); else passed++;
    checks++; if (retry_cnt[3:0] !== 4'd1) $display("FAIL loss_retry got %0d want 1", retry_cnt[3:0]); else passed++;
`ifdef GT_QPLL_LOSS_CNT_EN
    checks++; if (lock_loss_cnt !== 16'h0001) $display("FAIL loss_cnt got %h want 0001", lock_loss_cnt); else passed++;
`endif
  endtask

  task automatic test_start();
    int n = 0;
    qpll0lock = 2'b01; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 900 && !quad_fail[1]; i++) tick();
    checks++; if (quad_fail !== 2'b10) $display("FAIL start_pre_fail got %b want 10", quad_fail); else passed++;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if ({quad_fail, quad_locked, retry_cnt} !== 12'h000) $display("FAIL start_from_failed got %h want 000", {quad_fail, quad_locked, retry_cnt}); else passed++;
    checks++; if (qpll0reset !== 2'b11) $display("FAIL start_reset got %b want 11", qpll0reset); else passed++;
    checks++; if (obs_vec() !== exp_vec()) $display("FAIL start_model got %h want %h", obs_vec(), exp_vec()); else passed++;
    while (qpll0reset[1] && n < 40) begin tick(); n++; end
    checks++; if (n != RC) $display("FAIL start_reset_len got %0d want %0d", n, RC); else passed++;
    repeat (TO - 1) tick();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if ({quad_fail, retry_cnt[7:4]} !== 6'h00) $display("FAIL start_vs_timeout got %h want 00", {quad_fail, retry_cnt[7:4]}); else passed++;
    checks++; if (qpll0reset[1] !== 1'b1) $display("FAIL start_vs_timeout_reset got %b want 1", qpll0reset[1]); else passed++;
    checks++; if (obs_vec() !== exp_vec()) $display("FAIL start_timeout_model got %h want %h", obs_vec(), exp_vec()); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 399) == 0);
      for (int q = 0; q < N; q++) if ($urandom_range(0, 15) == 0) qpll0lock[q] = ~qpll0lock[q];
      tick();
      checks++; if (obs_vec() !== exp_vec()) $display("FAIL rand_cycle%0d got %h want %h", i, obs_vec(), exp_vec()); else passed++;
`ifdef GT_QPLL_LOSS_CNT_EN
      checks++; if (lock_loss_cnt !== {8'(m_loss[1]), 8'(m_loss[0])}) $display("FAIL rand_loss%0d got %h want %h", i, lock_loss_cnt, {8'(m_loss[1]), 8'(m_loss[0])}); else passed++;
`endif
    end
    start = 1'b0;
  endtask

  task automatic test_async_reset();
    qpll0lock = 2'b01; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 400 && retry_cnt[7:4] != 4'd1; i++) tick();
    repeat (20) tick();
    checks++; if ({quad_locked[0], retry_cnt[7:4], qpll0reset[1]} !== 6'b100010) $display("FAIL arst_precondition got %b want 100010", {quad_locked[0], retry_cnt[7:4], qpll0reset[1]}); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (qpll0reset !== 2'b11) $display("FAIL arst_qpll0reset got %b want 11", qpll0reset); else passed++;
    checks++; if ({quad_locked, quad_fail, all_locked} !== 5'b0) $display("FAIL arst_status got %b want 00000", {quad_locked, quad_fail, all_locked}); else passed++;
    checks++; if (retry_cnt !== 8'h00) $display("FAIL arst_retry got %h want 00", retry_cnt); else passed++;
`ifdef GT_QPLL_LOSS_CNT_EN
    checks++; if (lock_loss_cnt !== 16'h0000) $display("FAIL arst_loss got %h want 0000", lock_loss_cnt); else passed++;
`endif
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_quad1_fail();
    test_glitch();
    test_lock_loss();
    test_start();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/gt_qpll_reset_sequencer.md
Name: gt_qpll_reset_sequencer

Overview:
- Per-quad QPLL reset/lock sequencer for N_COMMON GTYE4 COMMON instances, for 100GbE CMAC-shared clocking.
- Drives each quad's qpll0reset and qualifies its lock with a synchroniser, a stability filter, a lock timeout and bounded retries.
- Reports per-quad and aggregate readiness to downstream GT channel reset logic.
- Sits between board reset/control logic and the COMMON wrapper's qpll0reset/qpll0lock pins.

Parameters:
- N_COMMON, 2, number of quads sequenced (1..4).
- RESET_CYCLES, 64, clk cycles qpll0reset is held high per attempt (>=2).
- LOCK_TIMEOUT, 65536, clk cycles allowed from reset release to qualified lock.
- LOCK_STABLE, 32, consecutive synchronised-high lock cycles required to declare lock (>=1).
- MAX_RETRIES, 3, extra reset attempts after the first timeout before declaring failure (0..15).

Ports:
- clk  in  1  free-running control clock; must not be derived from a QPLL.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; restarts all quads and clears retry counts and failures.
- qpll0lock  in  N_COMMON  raw lock from each COMMON; asynchronous to clk.
- qpll0reset  out  N_COMMON  reset to each COMMON.
- quad_locked  out  N_COMMON  per-quad qualified lock.
- quad_fail  out  N_COMMON  per-quad retries exhausted.
- all_locked  out  1  AND of quad_locked.
- retry_cnt  out  4*N_COMMON  per-quad retry count, quad i at bits [4i+3:4i].

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous, active-low (rst_n). rst_n assertion is valid at any time; the block returns immediately to reset values.
- Reset values:
  - qpll0reset = all 1s (PLLs held in reset).
  - quad_locked = 0, quad_fail = 0, all_locked = 0, retry_cnt = 0.
  - All FSMs in IDLE.
- Lock synchronisation: each qpll0lock bit passes through a 2-flop synchroniser, adding 2 cycles of latency. All lock decisions use the synchronised value.
- Per-quad FSM states: IDLE, RESET, WAIT_LOCK, LOCKED, FAILED.
- IDLE:
  - qpll0reset = 1.
  - Enters RESET on the first clk after rst_n deasserts, without needing start.
- RESET:
  - qpll0reset = 1 for exactly RESET_CYCLES cycles, then WAIT_LOCK.
- WAIT_LOCK:
  - qpll0reset = 0.
  - Timeout counter counts every cycle. The stable counter increments while the synchronised lock is 1 and clears to 0 when it is 0.
  - If stable reaches LOCK_STABLE, go to LOCKED.
  - Else if timeout reaches LOCK_TIMEOUT:
    - retry < MAX_RETRIES: retry_cnt++ and go to RESET.
    - otherwise: go to FAILED.
  - If both conditions hit on the same cycle, lock wins.
- LOCKED:
  - quad_locked = 1, asserted on the cycle the FSM enters LOCKED (registered output).
  - A synchronised lock of 0 for one cycle causes: quad_locked = 0 on the next cycle, transition to RESET, retry_cnt++ saturating at 15. Lock loss never leads directly to FAILED.
- FAILED:
  - qpll0reset = 1, quad_fail = 1.
  - Left only via start or rst_n.
- start:
  - Has priority over every transition in the same cycle.
  - All quads go to RESET, retry_cnt = 0, quad_fail = 0, quad_locked = 0.
  - A start during RESET restarts the RESET_CYCLES count.
- Quad independence: quads sequence independently. all_locked is registered and lags quad_locked by 1 cycle.
- Counter widths: $clog2(param+1), computed in the package. Counters never wrap; they saturate or are cleared on state entry.

Optional Feature:
- Macro: GT_QPLL_LOSS_CNT_EN.
- Defined:
  - Adds an output lock_loss_cnt, width 8*N_COMMON.
  - Per quad, the counter increments on each LOCKED-to-RESET lock-loss transition and saturates at 255.
  - Cleared by rst_n only; start does not clear it.
- Undefined: the port and counters are absent. All other behaviour is identical.

Decomposition:
- Package gt_qpll_seq_pkg:
  - qpll_state_e enum (IDLE, RESET, WAIT_LOCK, LOCKED, FAILED).
  - Function cnt_w(max) returning $clog2(max+1).
  - RETRY_W = 4 localparam.
- Sub-module gt_qpll_chan_fsm: one quad's synchroniser, counters and FSM. Instanced N_COMMON times in a generate loop.
- Top level: start fan-out, all_locked register, port packing.

Test Plan:
- Bench parameters: RESET_CYCLES=16, LOCK_TIMEOUT=256, LOCK_STABLE=8, MAX_RETRIES=2, N_COMMON=2.
- Power-up, lock tied high: release rst_n → qpll0reset high exactly 16 cycles after IDLE exit → quad_locked rises 2+8 cycles after reset release → all_locked one cycle after the second quad locks.
- Quad1 lock tied low:
  - quad1 performs 3 reset pulses 256 cycles apart.
  - retry_cnt[7:4] steps 1, 2.
  - quad_fail = 2'b10 and qpll0reset[1] = 1.
  - quad0 is unaffected.
- Glitch in WAIT_LOCK: lock high 7 cycles, low 1, high 8 → LOCKED only after the second run; stable counter verified cleared.
- Lock loss: drop quad0 lock for 1 cycle while LOCKED → quad_locked[0] falls, 16-cycle reset, retry_cnt[3:0] = 1, relock. With GT_QPLL_LOSS_CNT_EN defined, lock_loss_cnt[7:0] = 1.
- start while FAILED and start in the same cycle as a timeout → RESET taken, retry_cnt = 0, quad_fail cleared.
- rst_n asserted mid-WAIT_LOCK → qpll0reset = 2'b11 and all status outputs 0 asynchronously, before the next clk edge.
